// File: rtl/display_arbiter.sv
// ============================================================================
// Module   : display_arbiter
// Brief    : Shares the 8-digit display between time/smoker/clean sources,
//            with a preempting alert source and blanking on every switch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_arbiter #(
  parameter int BLANK_CYCLES = 1000,
  parameter int ALERT_CYCLES = 300000000,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic [7:0] time_digit1,
  input  logic [7:0] time_digit2,
  input  logic [7:0] time_tube_sel,
  input  logic [7:0] smoker_digit1,
  input  logic [7:0] smoker_digit2,
  input  logic [7:0] smoker_tube_sel,
  input  logic [7:0] clean_digit1,
  input  logic [7:0] clean_digit2,
  input  logic [7:0] clean_tube_sel,
  input  logic       alert_req,
  input  logic [7:0] alert_digit1,
  input  logic [7:0] alert_digit2,
  input  logic [7:0] alert_tube_sel,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic [7:0] tube_sel,
  output logic [1:0] src_sel,
  output logic       alert_active,
  output logic       blanking
);

  localparam logic [CNT_W-1:0] C_BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ALERT_LOAD = CNT_W'(ALERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2,
    ST_ALERT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_target, w_target_nxt;
  logic             r_pending, w_pending_nxt;
  logic [1:0]       w_decode;

  logic [7:0]       w_digit1, w_digit2, w_tube_sel;
  logic [1:0]       w_src_sel;
  logic             w_alert_active, w_blanking;

  always_comb begin
    w_decode = 2'd0;
    case (mode_state)
      3'b001, 3'b010, 3'b011: w_decode = 2'd1;
      3'b100:                 w_decode = 2'd2;
      default:                w_decode = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_target_nxt  = r_target;
    w_pending_nxt = r_pending;

    if (!machine_state) begin
      w_state_nxt   = ST_OFF;
      w_cnt_nxt     = '0;
      w_target_nxt  = 2'd0;
      w_pending_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt  = ST_BLANK;
          w_target_nxt = w_decode;
          w_cnt_nxt    = C_BLANK_LOAD;
        end
        ST_BLANK: begin
          w_pending_nxt = r_pending | alert_req;
          if (w_decode != r_target) begin
            w_target_nxt = w_decode;
            w_cnt_nxt    = C_BLANK_LOAD;
          end else if (r_cnt == '0) begin
            // A queued alert takes over straight from the blank, no flash of the source.
            if (r_pending | alert_req) begin
              w_state_nxt   = ST_ALERT;
              w_cnt_nxt     = C_ALERT_LOAD;
              w_pending_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_SHOW;
            end
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
        ST_SHOW: begin
          if (alert_req || r_pending) begin
            w_state_nxt   = ST_ALERT;
            w_cnt_nxt     = C_ALERT_LOAD;
            w_pending_nxt = 1'b0;
          end else if (w_decode != r_target) begin
            w_state_nxt  = ST_BLANK;
            w_target_nxt = w_decode;
            w_cnt_nxt    = C_BLANK_LOAD;
          end
        end
        default: begin
          if (alert_req) begin
            w_cnt_nxt = C_ALERT_LOAD;
          end else if (r_cnt == '0) begin
            w_state_nxt  = ST_BLANK;
            w_target_nxt = w_decode;
            w_cnt_nxt    = C_BLANK_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end
        end
      endcase
    end
  end

  // Pins are decoded from the upcoming state so they land together with it.
  always_comb begin
    w_digit1       = 8'h00;
    w_digit2       = 8'h00;
    w_tube_sel     = 8'h00;
    w_src_sel      = 2'd0;
    w_alert_active = 1'b0;
    w_blanking     = 1'b0;
    case (w_state_nxt)
      ST_BLANK: begin
        w_src_sel  = w_target_nxt;
        w_blanking = 1'b1;
      end
      ST_SHOW: begin
        w_src_sel = w_target_nxt;
        case (w_target_nxt)
          2'd1: begin
            w_digit1   = smoker_digit1;
            w_digit2   = smoker_digit2;
            w_tube_sel = smoker_tube_sel;
          end
          2'd2: begin
            w_digit1   = clean_digit1;
            w_digit2   = clean_digit2;
            w_tube_sel = clean_tube_sel;
          end
          default: begin
            w_digit1   = time_digit1;
            w_digit2   = time_digit2;
            w_tube_sel = time_tube_sel;
          end
        endcase
      end
      ST_ALERT: begin
        w_digit1       = alert_digit1;
        w_digit2       = alert_digit2;
        w_tube_sel     = alert_tube_sel;
        w_src_sel      = 2'd3;
        w_alert_active = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_target     <= 2'd0;
      r_pending    <= 1'b0;
      digit1       <= 8'h00;
      digit2       <= 8'h00;
      tube_sel     <= 8'h00;
      src_sel      <= 2'd0;
      alert_active <= 1'b0;
      blanking     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_pending    <= w_pending_nxt;
      digit1       <= w_digit1;
      digit2       <= w_digit2;
      tube_sel     <= w_tube_sel;
      src_sel      <= w_src_sel;
      alert_active <= w_alert_active;
      blanking     <= w_blanking;
    end
  end

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
Sequences the shared 8-digit seven-segment display between the three display sources: current-time, smoker gear display and self-clean countdown. It also accepts a one-shot alert source that preempts the display for a fixed time. Every source switch inserts a blanking interval to suppress ghosting. The block sits between the source modules and the top-level digit1/digit2/tube_sel pins, and is steered by machine_state and mode_state from mode_fsm.

Parameters:
BLANK_CYCLES, 1000, cycles of all-dark output on every source switch; must be >= 1
ALERT_CYCLES, 300000000, cycles the alert source is held (3 s at 100 MHz); must be >= 1
CNT_W, 32, width of the shared down-counter; must hold max(BLANK_CYCLES, ALERT_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (0 = reset)
machine_state  input  1  1 = powered on
mode_state  input  3  000 standby, 001/010/011 gear 1/2/3, 100 self-clean
time_digit1, time_digit2, time_tube_sel  input  8 each  current-time source
smoker_digit1, smoker_digit2, smoker_tube_sel  input  8 each  smoker source
clean_digit1, clean_digit2, clean_tube_sel  input  8 each  self-clean source
alert_req  input  1  single-cycle pulse; show alert source
alert_digit1, alert_digit2, alert_tube_sel  input  8 each  alert source
digit1, digit2, tube_sel  output  8 each  registered display pins
src_sel  output  2  source currently shown: 0 time, 1 smoker, 2 clean, 3 alert
alert_active  output  1  1 while in ALERT
blanking  output  1  1 while in BLANK

Behaviour:
- Reset (rst=0, asynchronous): state OFF; all outputs 0; counter 0; alert_pending 0; target 0.
- Decode (combinational): mode 000 -> 0; mode 001/010/011 -> 1; mode 100 -> 2; modes 101-111 -> 0.
- Outputs are registered. A source bus change appears on the pins 1 cycle later.
- Each source's digit2 drives digit2 and each source's digit1 drives digit1. No cross-wiring.
- States:
  - OFF: pins 0, src_sel 0. If machine_state=1: go to BLANK, target = decode, counter = BLANK_CYCLES-1.
  - BLANK: pins 0, blanking=1, src_sel=target.
    - If decode != target: update target and reload counter = BLANK_CYCLES-1.
    - Otherwise, when counter=0: go to SHOW. Otherwise decrement counter.
    - alert_req here sets alert_pending.
  - SHOW: pins = registered copy of the target source.
    - If alert_req or alert_pending: go to ALERT, counter = ALERT_CYCLES-1, clear alert_pending.
    - Else if decode != target: go to BLANK, target = decode, counter reloaded.
  - ALERT: pins = alert bus, alert_active=1, src_sel=3.
    - alert_req retriggers: counter = ALERT_CYCLES-1.
    - When counter=0: go to BLANK, target = decode (always blank after an alert, even if the mode is unchanged).
    - Mode changes during ALERT are not acted on until the alert ends.
- Priority, in every state: machine_state=0 beats everything. Next cycle: OFF, pins 0, alert_pending cleared, flags cleared.
- alert_req in OFF is ignored; nothing is latched.
- Simultaneous alert_req and mode change in SHOW: alert wins. The new mode is taken at the BLANK after the alert.
- The counter is never decremented below 0. It is only loaded on state entry or on a retrigger/reload.
- Reset mid-ALERT or mid-BLANK: immediate return to reset values. No residual pending alert.

Test Plan:
(All scenarios use BLANK_CYCLES=4, ALERT_CYCLES=10.)
1. Power-up: hold rst=0 for 3 cycles, release, machine_state=1, mode=000, time bus=8'hA5/8'h5A/8'h0F -> blanking=1 with pins 0 for 4 cycles. The next cycle, pins = A5/5A/0F and src_sel=0.
2. Mode switch: in SHOW, mode 000->010, smoker bus=8'h11/8'h22/8'h01 -> 4 blank cycles, then pins 11/22/01 and src_sel=1. Also check digit2=8'h22, not 8'h11.
3. Blank restart: during BLANK, at counter=1, mode 010->100 -> counter reloads. Check exactly 4 further blank cycles, then clean bus shown with src_sel=2.
4. Alert: in SHOW, pulse alert_req with alert bus=8'hFF/8'hFF/8'hFF -> pins FF for exactly 10 cycles with alert_active=1. Then 4 blank cycles, then the prior source. Retrigger at cycle 6 -> FF held 16 cycles in total.
5. Pending and power-off: alert_req during BLANK -> ALERT is entered directly after BLANK expires. Separately, machine_state=0 mid-ALERT -> pins 0 the next cycle and state OFF. Re-enabling power gives a normal blank, with no alert.
6. Async reset: drop rst between clock edges during ALERT -> outputs 0 before the next clk edge. alert_req pulses while OFF produce no ALERT after power-on.
